// File: rtl/cfh_pkg.sv
// Shared definitions for the CFH Walsh-Hadamard sequencer: word width,
// butterfly core latency and the sequencer state encoding.
package cfh_pkg;

    localparam int DW          = 12;
    localparam int BF_LAT_CFH2 = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        UNLOAD
    } state_t;

endpackage

// File: rtl/cfh_wb_pipe.sv
// Writeback tracker: a DEPTH-deep shift register of {valid, i0, i1} that
// retires each butterfly's buffer addresses in step with the core output.
module cfh_wb_pipe #(
    parameter int AW    = 3,
    parameter int DEPTH = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          push_valid,
    input  logic [AW-1:0] push_i0,
    input  logic [AW-1:0] push_i1,
    output logic          pop_valid,
    output logic [AW-1:0] pop_i0,
    output logic [AW-1:0] pop_i1,
    output logic          empty
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [AW-1:0]    i0_q [DEPTH];
    logic [AW-1:0]    i0_d [DEPTH];
    logic [AW-1:0]    i1_q [DEPTH];
    logic [AW-1:0]    i1_d [DEPTH];

    always_comb begin
        vld_d[0] = push_valid;
        i0_d[0]  = push_i0;
        i1_d[0]  = push_i1;
        for (int s = 1; s < DEPTH; s++) begin
            vld_d[s] = vld_q[s-1];
            i0_d[s]  = i0_q[s-1];
            i1_d[s]  = i1_q[s-1];
        end
    end

    // "Empty" looks only at entries that survive this cycle: the entry
    // retiring now has already been written back when the next stage issues.
    always_comb begin
        empty = 1'b1;
        for (int s = 0; s < DEPTH - 1; s++) begin
            if (vld_q[s]) empty = 1'b0;
        end
    end

    assign pop_valid = vld_q[DEPTH-1];
    assign pop_i0    = i0_q[DEPTH-1];
    assign pop_i1    = i1_q[DEPTH-1];

    always_ff @(posedge CLK) begin
        if (RESET) vld_q <= '0;
        else       vld_q <= vld_d;
        i0_q <= i0_d;
        i1_q <= i1_d;
    end

endmodule

// File: rtl/cfh_wht_sequencer.sv
// In-place N-point normalized Walsh-Hadamard sequencer: loads N samples,
// runs LOG2N butterfly stages through an external 2-point core, unloads.
module cfh_wht_sequencer #(
    parameter int N      = 8,
    parameter int LOG2N  = 3,
    parameter int DW     = cfh_pkg::DW,
    parameter int BF_LAT = cfh_pkg::BF_LAT_CFH2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] bf_i0,
    output logic [DW-1:0] bf_i1,
    input  logic [DW-1:0] bf_o0,
    input  logic [DW-1:0] bf_o1
);

    import cfh_pkg::*;

    localparam int KW = LOG2N - 1;
    localparam int SW = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    state_t           state_q, state_d;
    logic [LOG2N-1:0] cnt_q, cnt_d;
    logic [KW-1:0]    k_q, k_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic             done_q, done_d;
    logic [DW-1:0]    mem_q [N];
    logic [DW-1:0]    mem_d [N];

    logic [LOG2N-1:0] i0, i1;
    logic             push_valid;
    logic             pop_valid, pipe_empty;
    logic [LOG2N-1:0] pop_i0, pop_i1;

    // Lower butterfly address: k with a zero bit inserted at position s.
    function automatic logic [LOG2N-1:0] lower_index(input logic [KW-1:0] k,
                                                     input logic [SW-1:0] s);
        logic [LOG2N-1:0] kx, lo;
        kx = {1'b0, k};
        lo = (LOG2N'(1) << s) - LOG2N'(1);
        return ((kx & ~lo) << 1) | (kx & lo);
    endfunction

    cfh_wb_pipe #(
        .AW    (LOG2N),
        .DEPTH (BF_LAT)
    ) u_wb_pipe (
        .CLK        (CLK),
        .RESET      (RESET),
        .push_valid (push_valid),
        .push_i0    (i0),
        .push_i1    (i1),
        .pop_valid  (pop_valid),
        .pop_i0     (pop_i0),
        .pop_i1     (pop_i1),
        .empty      (pipe_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        stage_d    = stage_q;
        done_d     = 1'b0;
        mem_d      = mem_q;
        push_valid = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_data   = '0;
        out_last   = 1'b0;
        bf_i0      = '0;
        bf_i1      = '0;
        i0         = lower_index(k_q, stage_q);
        i1         = i0 | (LOG2N'(1) << stage_q);

        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mem_d[cnt_q] = in_data;
                    if (cnt_q == LOG2N'(N - 1)) begin
                        cnt_d   = '0;
                        k_d     = '0;
                        stage_d = '0;
                        state_d = ISSUE;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            ISSUE: begin
                bf_i0      = mem_q[i0];
                bf_i1      = mem_q[i1];
                push_valid = 1'b1;
                if (k_q == KW'(N / 2 - 1)) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    if (stage_q == SW'(LOG2N - 1)) begin
                        cnt_d   = '0;
                        state_d = UNLOAD;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        k_d     = '0;
                        state_d = ISSUE;
                    end
                end
            end
            UNLOAD: begin
                out_valid = 1'b1;
                out_data  = mem_q[cnt_q];
                out_last  = (cnt_q == LOG2N'(N - 1));
                if (out_ready) begin
                    if (cnt_q == LOG2N'(N - 1)) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop_valid && (state_q == ISSUE || state_q == DRAIN)) begin
            mem_d[pop_i0] = bf_o0;
            mem_d[pop_i1] = bf_o1;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            done_q  <= done_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_cfh_wht_sequencer.sv
// Directed bench for cfh_wht_sequencer with a CFH_2 2-point core model on
// the bf_* ports (x0.7071 as 181/256, magnitude truncated toward zero).
module tb_cfh_wht_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [11:0] bf_i0, bf_i1;
    logic [11:0] bf_o0 = '0;
    logic [11:0] bf_o1 = '0;

    logic [11:0] ca_q = '0;
    logic [11:0] cb_q = '0;

    int          nvec = 0;
    int          nerr = 0;
    logic [11:0] vec [8];
    logic [11:0] got [8];
    logic        lst [8];
    int          g;
    logic        flag;

    always #5 CLK = ~CLK;

    cfh_wht_sequencer #(
        .N      (8),
        .LOG2N  (3),
        .DW     (12),
        .BF_LAT (2)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .bf_i0     (bf_i0),
        .bf_i1     (bf_i1),
        .bf_o0     (bf_o0),
        .bf_o1     (bf_o1)
    );

    function automatic int sm2i(input logic [11:0] v);
        int m;
        m = int'(v[10:0]);
        return v[11] ? -m : m;
    endfunction

    function automatic logic [11:0] sm_scale(input int s);
        int m;
        m = (s < 0) ? -s : s;
        m = (m * 181) / 256;
        if (m > 2047) m = 2047;
        return {(s < 0) && (m != 0), m[10:0]};
    endfunction

    // CFH_2 core: input register, then output register.
    always @(posedge CLK) begin
        ca_q  <= bf_i0;
        cb_q  <= bf_i1;
        bf_o0 <= sm_scale(sm2i(ca_q) + sm2i(cb_q));
        bf_o1 <= sm_scale(sm2i(ca_q) - sm2i(cb_q));
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load8();
        int w;
        for (int i = 0; i < 8; i++) begin
            w = 0;
            while (in_ready !== 1'b1 && w < 50) begin
                tick();
                w++;
            end
            check("load_ready", 16'(in_ready), 16'h1);
            in_valid = 1'b1;
            in_data  = vec[i];
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic unload8(input int stall_idx);
        int          w;
        int          ndone;
        logic [11:0] held;
        logic        ok;
        w     = 0;
        ndone = 0;
        while (out_valid !== 1'b1 && w < 100) begin
            if (done === 1'b1) ndone++;
            tick();
            w++;
        end
        check("unload_start", 16'(out_valid), 16'h1);
        out_ready = 1'b1;
        for (int idx = 0; idx < 8; idx++) begin
            if (idx == stall_idx) begin
                out_ready = 1'b0;
                held      = out_data;
                ok        = 1'b1;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    if (out_data !== held || out_valid !== 1'b1 || out_last !== 1'b0) ok = 1'b0;
                end
                check("stall_hold", 16'(ok), 16'h1);
                out_ready = 1'b1;
            end
            if (done === 1'b1) ndone++;
            got[idx] = out_data;
            lst[idx] = out_last;
            tick();
        end
        out_ready = 1'b0;
        if (done === 1'b1) ndone++;
        check("done_pulse", 16'(done), 16'h1);
        check("valid_after_last", 16'(out_valid), 16'h0);
        tick();
        if (done === 1'b1) ndone++;
        check("done_once", 16'(ndone), 16'h1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for 3 cycles
        RESET = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", 16'(in_ready), 16'h0);
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_out_last", 16'(out_last), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_bf_i0", 16'(bf_i0), 16'h0);
        check("rst_bf_i1", 16'(bf_i1), 16'h0);
        check("rst_out_data", 16'(out_data), 16'h0);
        RESET = 1'b0;
        tick();
        check("post_rst_in_ready", 16'(in_ready), 16'h1);
        check("post_rst_busy", 16'(busy), 16'h1);

        // Zeros
        for (int i = 0; i < 8; i++) vec[i] = 12'h000;
        load8();
        unload8(-1);
        for (int i = 0; i < 8; i++) begin
            check("zeros_data", 16'(got[i]), 16'h000);
            check("zeros_last", 16'(lst[i]), (i == 7) ? 16'h1 : 16'h0);
        end

        // Impulse: 256 -> 181 -> 127 -> 89 on every output
        vec = '{12'h100, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        load8();
        unload8(-1);
        for (int i = 0; i < 8; i++) check("impulse_data", 16'(got[i]), 16'h059);

        // Alternating +100/-100, in_valid held high through compute
        vec = '{12'h064, 12'h864, 12'h064, 12'h864, 12'h064, 12'h864, 12'h064, 12'h864};
        load8();
        in_valid = 1'b1;
        in_data  = 12'h7FF;
        g        = 0;
        flag     = 1'b0;
        while (out_valid !== 1'b1 && g < 100) begin
            if (in_ready !== 1'b0) flag = 1'b1;
            tick();
            g++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("compute_in_ready", 16'(flag), 16'h0);
        check("compute_cycles", 16'(g), 16'd18);
        unload8(-1);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) begin
                nvec++;
                assert (got[1][11] === 1'b0 && got[1][10:0] >= 11'd281 && got[1][10:0] <= 11'd283) else begin
                    nerr++;
                    $error("FAIL alt_out1: observed %0h expected 119..11b", got[1]);
                end
            end else begin
                check("alt_zero", 16'(got[i]), 16'h000);
            end
        end

        // x0=x1=256: even outputs 180, odd outputs 0; stall 5 cycles at index 3
        vec = '{12'h100, 12'h100, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        load8();
        unload8(3);
        for (int i = 0; i < 8; i++) begin
            check("stall_data", 16'(got[i]), (i % 2 == 0) ? 16'h0B4 : 16'h000);
            check("stall_last", 16'(lst[i]), (i == 7) ? 16'h1 : 16'h0);
        end

        // Reset while issuing stage 1, k=2
        vec = '{12'h100, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000};
        load8();
        check("issue_s0k0_bf_i0", 16'(bf_i0), 16'h100);
        check("issue_s0k0_bf_i1", 16'(bf_i1), 16'h000);
        repeat (6) tick();
        check("issue_s1k0_bf_i0", 16'(bf_i0), 16'h0B5);
        check("issue_s1k0_bf_i1", 16'(bf_i1), 16'h000);
        repeat (2) tick();
        RESET = 1'b1;
        tick();
        check("midrst_busy", 16'(busy), 16'h0);
        check("midrst_in_ready", 16'(in_ready), 16'h0);
        check("midrst_bf_i0", 16'(bf_i0), 16'h000);
        check("midrst_out_valid", 16'(out_valid), 16'h0);
        RESET = 1'b0;
        tick();
        check("midrst_reload_ready", 16'(in_ready), 16'h1);
        load8();
        unload8(-1);
        for (int i = 0; i < 8; i++) check("reload_impulse", 16'(got[i]), 16'h059);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
